// File: rtl/ysyx_22050019_lut_table.sv
// Registered key/data table driving the packed lut bus, plus a sequential reverse-lookup engine.
// Define YSYX_22050019_LUT_DUP_CHECK_EN to reject writes that would duplicate a key held by another entry.
module ysyx_22050019_lut_table #(
   parameter  int NR_KEY   = 4,
   parameter  int KEY_LEN  = 3,
   parameter  int DATA_LEN = 32,
   localparam int IDX_W    = $clog2(NR_KEY),
   localparam int PAIR_LEN = KEY_LEN + DATA_LEN
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [IDX_W-1:0]           wr_idx,
   input  logic [KEY_LEN-1:0]         wr_key,
   input  logic [DATA_LEN-1:0]        wr_data,
   input  logic                       clr,
   output logic [NR_KEY*PAIR_LEN-1:0] lut,
   output logic [NR_KEY-1:0]          entry_vld,
   output logic                       wr_err,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic [DATA_LEN-1:0]        req_data,
   output logic                       resp_valid,
   input  logic                       resp_ready,
   output logic                       resp_hit,
   output logic [KEY_LEN-1:0]         resp_key,
   output logic [IDX_W-1:0]           resp_idx
);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_RESP} state_t;

   logic [KEY_LEN-1:0]  key_q  [NR_KEY];
   logic [KEY_LEN-1:0]  key_d  [NR_KEY];
   logic [DATA_LEN-1:0] data_q [NR_KEY];
   logic [DATA_LEN-1:0] data_d [NR_KEY];
   logic [NR_KEY-1:0]   vld_q, vld_d;
   logic                idx_ok;
   logic                dup_hit;
   logic                wr_rej;

   state_t              state_q;
   logic [IDX_W-1:0]    ptr_q;
   logic [DATA_LEN-1:0] sdata_q;
   logic                req_ready_q;
   logic                resp_valid_q;
   logic                resp_hit_q;
   logic [KEY_LEN-1:0]  resp_key_q;
   logic [IDX_W-1:0]    resp_idx_q;

   assign idx_ok = (int'(wr_idx) < NR_KEY);

   // Another valid entry already owning wr_key blocks the write when the check is built in.
   always_comb begin
      dup_hit = 1'b0;
`ifdef YSYX_22050019_LUT_DUP_CHECK_EN
      for (int n = 0; n < NR_KEY; n++) begin
         if (vld_q[n] && (key_q[n] == wr_key) && (n != int'(wr_idx))) begin
            dup_hit = 1'b1;
         end
      end
`endif
   end

   assign wr_rej = wr_en && !clr && idx_ok && dup_hit;

   always_comb begin
      key_d  = key_q;
      data_d = data_q;
      vld_d  = vld_q;
      if (clr) begin
         for (int n = 0; n < NR_KEY; n++) begin
            key_d[n]  = '0;
            data_d[n] = '0;
         end
         vld_d = '0;
      end else if (wr_en && idx_ok && !wr_rej) begin
         key_d[wr_idx]  = wr_key;
         data_d[wr_idx] = wr_data;
         vld_d[wr_idx]  = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int n = 0; n < NR_KEY; n++) begin
            key_q[n]  <= '0;
            data_q[n] <= '0;
         end
         vld_q <= '0;
      end else begin
         key_q  <= key_d;
         data_q <= data_d;
         vld_q  <= vld_d;
      end
   end

`ifdef YSYX_22050019_LUT_DUP_CHECK_EN
   logic wr_err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_err_q <= 1'b0;
      end else begin
         wr_err_q <= wr_rej;
      end
   end

   assign wr_err = wr_err_q;
`else
   assign wr_err = 1'b0;
`endif

   // Invalid entries only arise from reset or clr, both of which zero them, so registers export directly.
   always_comb begin
      lut = '0;
      for (int n = 0; n < NR_KEY; n++) begin
         lut[PAIR_LEN*n +: PAIR_LEN] = {key_q[n], data_q[n]};
      end
   end

   assign entry_vld = vld_q;

   // Scan compares pre-edge table contents; the result is latched one cycle before resp_valid rises.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         ptr_q        <= '0;
         sdata_q      <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_hit_q   <= 1'b0;
         resp_key_q   <= '0;
         resp_idx_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  sdata_q     <= req_data;
                  ptr_q       <= '0;
                  req_ready_q <= 1'b0;
                  state_q     <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (vld_q[ptr_q] && (data_q[ptr_q] == sdata_q)) begin
                  resp_hit_q <= 1'b1;
                  resp_key_q <= key_q[ptr_q];
                  resp_idx_q <= ptr_q;
                  state_q    <= S_RESP;
               end else if (ptr_q == IDX_W'(NR_KEY-1)) begin
                  resp_hit_q <= 1'b0;
                  resp_key_q <= '0;
                  resp_idx_q <= '0;
                  state_q    <= S_RESP;
               end else begin
                  ptr_q <= ptr_q + IDX_W'(1);
               end
            end
            S_RESP: begin
               if (!resp_valid_q) begin
                  resp_valid_q <= 1'b1;
               end else if (resp_ready) begin
                  resp_valid_q <= 1'b0;
                  req_ready_q  <= 1'b1;
                  state_q      <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_hit   = resp_hit_q;
   assign resp_key   = resp_key_q;
   assign resp_idx   = resp_idx_q;

endmodule
